// File: rtl/spi_host_pkg.sv
// Shared types and constants for the host-side SPI master: FSM states, transfer
// modes, word/count widths and the saturating word-count helper.
package spi_host_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 12;
  localparam logic [WORD_W-1:0] TERM_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    GAP
  } state_e;

  typedef enum logic {
    MODE_WRITE,
    MODE_DRAIN
  } mode_e;

  // Count sticks at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/spi_host_master_if.sv
// Bus bundle between host logic and spi_host_master: tx word handshake,
// drain request, rx result stream, status and the four SPI pins.
interface spi_host_master_if;

  logic                             tx_valid;
  logic                             tx_ready;
  logic [spi_host_pkg::WORD_W-1:0]  tx_data;
  logic                             drain_start;
  logic                             rx_valid;
  logic [spi_host_pkg::WORD_W-1:0]  rx_data;
  logic                             rx_last;
  logic                             drain_err;
  logic                             busy;
  logic                             sck;
  logic                             ss_n;
  logic                             mosi;
  logic                             miso;

  modport master (
    input  tx_valid, tx_data, drain_start, miso,
    output tx_ready, rx_valid, rx_data, rx_last, drain_err, busy, sck, ss_n, mosi
  );

  modport slave (
    output tx_valid, tx_data, drain_start, miso,
    input  tx_ready, rx_valid, rx_data, rx_last, drain_err, busy, sck, ss_n, mosi
  );

endinterface

// File: rtl/spi_host_sckgen.sv
// SCK half-period timer: while run_i is high, strobes phase_done_o on the last
// of every CLK_DIV clk cycles; idles at zero when run_i is low.
module spi_host_sckgen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic phase_done_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign phase_done_o = run_i && (cnt_q == 8'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (!run_i || phase_done_o) begin
      cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_host_master.sv
// Host-side SPI mode-0 master: writes 32-bit words, or drains result words until
// TERM_WORD or MAX_WORDS. Build option SPI_HOST_TERM_STRIP_EN zeroes the terminator's rx_data.
module spi_host_master
  import spi_host_pkg::*;
#(
  parameter int unsigned       CLK_DIV    = 4,
  parameter int unsigned       GAP_CYCLES = 8,
  parameter int unsigned       MAX_WORDS  = 2048,
  parameter logic [WORD_W-1:0] TERM_WORD  = TERM_WORD_DEF
) (
  input logic               clk,
  input logic               reset,
  spi_host_master_if.master spi
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_e            state_q, state_d;
  mode_e             mode_q;
  logic [WORD_W-1:0] shift_q;
  logic [4:0]        bit_q;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [GW-1:0]     gap_q;
  logic              stop_q;
  logic [1:0]        miso_sync_q;
  logic              rx_valid_q, rx_last_q, drain_err_q;
  logic [WORD_W-1:0] rx_data_q;

  logic in_frame, phase_done, frame_end, gap_done, term_hit, cap_hit;

  assign in_frame   = (state_q == SETUP) || (state_q == SHIFT_HI) || (state_q == SHIFT_LO);
  assign frame_end  = (state_q == SHIFT_LO) && phase_done && (bit_q == 5'd31);
  assign gap_done   = (state_q == GAP) && (gap_q == GW'(GAP_CYCLES - 1));
  assign word_cnt_d = sat_inc(word_cnt_q);
  assign term_hit   = (shift_q == TERM_WORD);
  assign cap_hit    = (word_cnt_d == CNT_W'(MAX_WORDS));

  spi_host_sckgen #(
    .CLK_DIV (CLK_DIV)
  ) u_sckgen (
    .clk          (clk),
    .reset        (reset),
    .run_i        (in_frame),
    .phase_done_o (phase_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (spi.drain_start || spi.tx_valid) state_d = SETUP;
      SETUP:    if (phase_done) state_d = SHIFT_HI;
      SHIFT_HI: if (phase_done) state_d = SHIFT_LO;
      SHIFT_LO: if (phase_done) state_d = (bit_q == 5'd31) ? GAP : SHIFT_HI;
      GAP:      if (gap_done) state_d = (mode_q == MODE_DRAIN && !stop_q) ? SETUP : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // tx_ready looks at drain_start combinationally so a same-cycle drain request wins.
  always_comb begin
    spi.tx_ready = 1'b0;
    spi.sck      = 1'b0;
    spi.ss_n     = 1'b1;
    spi.mosi     = 1'b0;
    spi.busy     = (state_q != IDLE);
    case (state_q)
      IDLE:     spi.tx_ready = !reset && !spi.drain_start;
      SETUP, SHIFT_LO: begin
        spi.ss_n = 1'b0;
        spi.mosi = shift_q[WORD_W-1];
      end
      SHIFT_HI: begin
        spi.ss_n = 1'b0;
        spi.sck  = 1'b1;
        spi.mosi = shift_q[WORD_W-1];
      end
      default: ;
    endcase
  end

  assign spi.rx_valid  = rx_valid_q;
  assign spi.rx_data   = rx_data_q;
  assign spi.rx_last   = rx_last_q;
  assign spi.drain_err = drain_err_q;

  // One register serves both directions: tx bits leave from the top while miso enters at the bottom.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q      <= MODE_WRITE;
      shift_q     <= '0;
      bit_q       <= '0;
      word_cnt_q  <= '0;
      gap_q       <= '0;
      stop_q      <= 1'b0;
      miso_sync_q <= '0;
      rx_valid_q  <= 1'b0;
      rx_last_q   <= 1'b0;
      rx_data_q   <= '0;
      drain_err_q <= 1'b0;
    end else begin
      miso_sync_q <= {miso_sync_q[0], spi.miso};
      rx_valid_q  <= 1'b0;
      rx_last_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          bit_q  <= '0;
          stop_q <= 1'b0;
          if (spi.drain_start) begin
            shift_q     <= '0;
            mode_q      <= MODE_DRAIN;
            word_cnt_q  <= '0;
            drain_err_q <= 1'b0;
          end else if (spi.tx_valid) begin
            shift_q <= spi.tx_data;
            mode_q  <= MODE_WRITE;
          end
        end
        SHIFT_HI: begin
          if (phase_done) shift_q <= {shift_q[WORD_W-2:0], miso_sync_q[1]};
        end
        SHIFT_LO: begin
          if (phase_done) begin
            bit_q <= bit_q + 5'd1;
            gap_q <= '0;
          end
          if (frame_end && mode_q == MODE_DRAIN) begin
            rx_valid_q <= 1'b1;
            rx_last_q  <= term_hit || cap_hit;
            stop_q     <= term_hit || cap_hit;
            word_cnt_q <= word_cnt_d;
            if (cap_hit && !term_hit) drain_err_q <= 1'b1;
`ifdef SPI_HOST_TERM_STRIP_EN
            rx_data_q <= term_hit ? '0 : shift_q;
`else
            rx_data_q <= shift_q;
`endif
          end
        end
        GAP: begin
          gap_q <= gap_q + GW'(1);
          if (gap_done) shift_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host_master.sv
// Directed bench for spi_host_master with a behavioural mode-0 slave and an rx scoreboard;
// expects the same SPI_HOST_TERM_STRIP_EN setting as the design build.
module tb_spi_host_master;

  localparam int CLK_DIV    = 4;
  localparam int GAP_CYCLES = 8;
  localparam int MAX_WORDS  = 4;
  localparam int FRAME_LEN  = 65 * CLK_DIV;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  spi_host_master_if spi ();

  spi_host_master #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES),
    .MAX_WORDS  (MAX_WORDS),
    .TERM_WORD  (32'hFFFF_FFFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .spi   (spi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t expQ[$];

  logic [31:0] slaveWords[$];
  logic [31:0] slaveFill = 32'h0000_0C0D;
  int          slaveStart = 0;
  int          slaveFrameNo = 0;

  int   rxPulseCount = 0;
  int   readyBad = 0;
  int   framesSeen = 0;
  int   highRun = 0;
  int   minGap = 1000000;
  logic prevSsN = 1'b1;

  logic [31:0] streamWords [4] = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'hFFFF_FFFF};

  // Mode-0 slave: first bit ready when ss_n falls, next bit after every sck fall.
  initial begin
    int          idx;
    logic [31:0] slaveShift;
    spi.miso = 1'b0;
    forever begin
      @(negedge spi.ss_n);
      idx = slaveFrameNo - slaveStart;
      slaveFrameNo++;
      slaveShift = (idx >= 0 && idx < slaveWords.size()) ? slaveWords[idx] : slaveFill;
      spi.miso = slaveShift[31];
      forever begin
        @(negedge spi.sck or posedge spi.ss_n);
        if (spi.ss_n === 1'b1) break;
        slaveShift = {slaveShift[30:0], 1'b0};
        spi.miso = slaveShift[31];
      end
    end
  end

  always @(posedge clk) begin
    if (spi.rx_valid === 1'b1) rxPulseCount <= rxPulseCount + 1;
    if (spi.tx_ready === 1'b1 && spi.busy !== 1'b0) readyBad <= readyBad + 1;
    prevSsN <= spi.ss_n;
    if (spi.ss_n === 1'b1) begin
      highRun <= highRun + 1;
    end else begin
      highRun <= 0;
      if (prevSsN === 1'b1) begin
        framesSeen <= framesSeen + 1;
        if (framesSeen > 0 && highRun < minGap) minGap <= highRun;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] word);
    int g = 0;
    spi.tx_valid = 1'b1;
    spi.tx_data  = word;
    #1;
    while (spi.tx_ready !== 1'b1 && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    checkOutput("txReady", 32'(spi.tx_ready), 1);
    @(negedge clk);
    spi.tx_valid = 1'b0;
  endtask

  task automatic measureFrame(output int len, output int rises, output logic [31:0] word);
    int   g = 0;
    logic prevSck = 1'b0;
    len = 0;
    rises = 0;
    word = '0;
    while (spi.ss_n === 1'b1 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    while (spi.ss_n === 1'b0 && g < 5000) begin
      len++;
      if (spi.sck === 1'b1 && prevSck === 1'b0) begin
        rises++;
        word = {word[30:0], spi.mosi};
      end
      prevSck = spi.sck;
      @(negedge clk);
      g++;
    end
  endtask

  task automatic checkPulse();
    int   g = 0;
    exp_t e;
    while (spi.rx_valid !== 1'b1 && g < 4 * FRAME_LEN) begin
      @(negedge clk);
      g++;
    end
    checkOutput("rxValid", 32'(spi.rx_valid), 1);
    e = expQ.pop_front();
    checkOutput("rxData", spi.rx_data, e.data);
    checkOutput("rxLast", 32'(spi.rx_last), 32'(e.last));
    checkOutput("drainErr", 32'(spi.drain_err), 32'(e.err));
    @(negedge clk);
  endtask

  initial begin
    int          len, rises, pulsesBefore, framesBefore;
    logic [31:0] word;
    logic [31:0] termExp;
`ifdef SPI_HOST_TERM_STRIP_EN
    termExp = 32'h0;
`else
    termExp = 32'hFFFF_FFFF;
`endif
    reset = 1'b1;
    spi.tx_valid = 1'b0;
    spi.tx_data = '0;
    spi.drain_start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstTxReady", 32'(spi.tx_ready), 0);
    checkOutput("rstRxValid", 32'(spi.rx_valid), 0);
    checkOutput("rstRxLast", 32'(spi.rx_last), 0);
    checkOutput("rstRxData", spi.rx_data, 0);
    checkOutput("rstDrainErr", 32'(spi.drain_err), 0);
    checkOutput("rstBusy", 32'(spi.busy), 0);
    checkOutput("rstSck", 32'(spi.sck), 0);
    checkOutput("rstSsN", 32'(spi.ss_n), 1);
    checkOutput("rstMosi", 32'(spi.mosi), 0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] single write");
    pulsesBefore = rxPulseCount;
    applyStimulus(32'hA5A5_0001);
    measureFrame(len, rises, word);
    checkOutput("wrSsLowLen", len, FRAME_LEN);
    checkOutput("wrSckRises", rises, 32);
    checkOutput("wrMosiWord", word, 32'hA5A5_0001);
    repeat (GAP_CYCLES + 2) @(negedge clk);
    checkOutput("wrNoRxPulse", rxPulseCount - pulsesBefore, 0);
    checkOutput("wrIdleAfter", 32'(spi.busy), 0);

    $display("[TB] stream of four words");
    framesBefore = framesSeen;
    foreach (streamWords[i]) begin
      applyStimulus(streamWords[i]);
      measureFrame(len, rises, word);
      checkOutput("streamMosiWord", word, streamWords[i]);
    end
    repeat (GAP_CYCLES + 2) @(negedge clk);
    checkOutput("streamFrames", framesSeen - framesBefore, 4);
    checkOutput("streamGapMin", 32'(minGap >= GAP_CYCLES), 1);
    checkOutput("readyOnlyIdle", readyBad, 0);
    checkOutput("streamNoRxPulse", rxPulseCount - pulsesBefore, 0);

    $display("[TB] drain with same-cycle tx_valid");
    slaveWords = '{32'h0000_0011, 32'h0000_0022, 32'hFFFF_FFFF};
    slaveStart = slaveFrameNo;
    expQ.push_back('{32'h0000_0011, 1'b0, 1'b0});
    expQ.push_back('{32'h0000_0022, 1'b0, 1'b0});
    expQ.push_back('{termExp, 1'b1, 1'b0});
    pulsesBefore = rxPulseCount;
    spi.tx_valid = 1'b1;
    spi.tx_data = 32'hDEAD_BEEF;
    spi.drain_start = 1'b1;
    #1;
    checkOutput("prioTxReady", 32'(spi.tx_ready), 0);
    @(negedge clk);
    spi.tx_valid = 1'b0;
    spi.drain_start = 1'b0;
    checkOutput("prioBusy", 32'(spi.busy), 1);
    measureFrame(len, rises, word);
    checkOutput("drainMosiZero", word, 0);
    repeat (3) checkPulse();
    repeat (6) @(negedge clk);
    checkOutput("drainBusyInGap", 32'(spi.busy), 1);
    @(negedge clk);
    checkOutput("drainBusyFall", 32'(spi.busy), 0);
    checkOutput("drainPulseCount", rxPulseCount - pulsesBefore, 3);

    $display("[TB] drain hitting the word cap");
    slaveWords.delete();
    slaveStart = slaveFrameNo;
    for (int i = 0; i < MAX_WORDS; i++) begin
      expQ.push_back('{slaveFill, i == MAX_WORDS - 1, i == MAX_WORDS - 1});
    end
    pulsesBefore = rxPulseCount;
    spi.drain_start = 1'b1;
    @(negedge clk);
    spi.drain_start = 1'b0;
    repeat (MAX_WORDS) checkPulse();
    repeat (20) @(negedge clk);
    checkOutput("capPulseCount", rxPulseCount - pulsesBefore, MAX_WORDS);
    checkOutput("capIdle", 32'(spi.busy), 0);
    checkOutput("capErrSticky", 32'(spi.drain_err), 1);
    slaveWords = '{32'hFFFF_FFFF};
    slaveStart = slaveFrameNo;
    expQ.push_back('{termExp, 1'b1, 1'b0});
    spi.drain_start = 1'b1;
    @(negedge clk);
    spi.drain_start = 1'b0;
    checkOutput("errClearedOnStart", 32'(spi.drain_err), 0);
    checkPulse();
    repeat (GAP_CYCLES + 2) @(negedge clk);
    checkOutput("termDrainIdle", 32'(spi.busy), 0);

    $display("[TB] reset during a frame");
    begin
      int g = 0;
      applyStimulus(32'h1234_5678);
      while (spi.sck !== 1'b1 && g < 100) begin
        @(negedge clk);
        g++;
      end
      checkOutput("abortInShiftHi", 32'(spi.sck), 1);
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abortSsN", 32'(spi.ss_n), 1);
    checkOutput("abortSck", 32'(spi.sck), 0);
    checkOutput("abortBusy", 32'(spi.busy), 0);
    checkOutput("abortMosi", 32'(spi.mosi), 0);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(32'h0F0F_F0F0);
    measureFrame(len, rises, word);
    checkOutput("recoverSsLowLen", len, FRAME_LEN);
    checkOutput("recoverMosiWord", word, 32'h0F0F_F0F0);
    repeat (GAP_CYCLES + 2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
